// File: rtl/nco_quad_upconverter_if.sv
// Stream bundle for the quadrature up-converter: sample input and product output.
// master drives in_* / out_ready; slave (the converter) drives in_ready / out_*.
interface nco_quad_upconverter_if #(
  parameter int DATA_W = 16
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_i;
  logic signed [DATA_W-1:0] in_q;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W+8:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_i,
    output in_q,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_i,
    input  in_q,
    output out_valid,
    input  out_ready,
    output out_data
  );

endinterface

// File: rtl/nco_quad_upconverter.sv
// NCO quadrature up-converter: y = I*cos - Q*sin over a 3-stage valid/ready pipeline.
// Ports: clk, rst_n, phase_inc/phase_clr, rom_index/rom_cos/rom_sin, bus (stream if).
module nco_quad_upconverter #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               phase_clr,
  output logic [7:0]         rom_index,
  input  logic signed [7:0]  rom_cos,
  input  logic signed [7:0]  rom_sin,
  nco_quad_upconverter_if.slave bus
);

  localparam int PW = DATA_W + 8;
  localparam int OW = DATA_W + 9;

  logic               en;
  logic               accept;
  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W-1:0] phase_now;

  logic                     v1;
  logic signed [DATA_W-1:0] i1;
  logic signed [DATA_W-1:0] q1;
  logic signed [7:0]        c1;
  logic signed [7:0]        s1;

  logic          v2;
  logic [PW-1:0] p_i;
  logic [PW-1:0] p_q;

  logic [PW-1:0] i1x;
  logic [PW-1:0] q1x;
  logic [PW-1:0] c1x;
  logic [PW-1:0] s1x;
  logic [OW-1:0] diff;

  logic          ov;
  logic [OW-1:0] od;

  // A single enable freezes every stage whenever the head is blocked.
  assign en     = !ov || bus.out_ready;
  assign accept = bus.in_valid && en;

  assign bus.in_ready  = en;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;

  assign phase_now = phase_clr ? '0 : phase_acc;
  assign rom_index = phase_now[PHASE_W-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
    end else if (accept) begin
      phase_acc <= phase_now + phase_inc;
    end else begin
      phase_acc <= phase_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      i1 <= '0;
      q1 <= '0;
      c1 <= '0;
      s1 <= '0;
    end else if (en) begin
      v1 <= accept;
      i1 <= bus.in_i;
      q1 <= bus.in_q;
      c1 <= rom_cos;
      s1 <= rom_sin;
    end
  end

  // Sign-extend to the product width; the low PW bits of the
  // unsigned product are the exact signed product.
  assign i1x = {{8{i1[DATA_W-1]}}, i1};
  assign q1x = {{8{q1[DATA_W-1]}}, q1};
  assign c1x = {{DATA_W{c1[7]}}, c1};
  assign s1x = {{DATA_W{s1[7]}}, s1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      p_i <= '0;
      p_q <= '0;
    end else if (en) begin
      v2  <= v1;
      p_i <= i1x * c1x;
      p_q <= q1x * s1x;
    end
  end

  assign diff = {p_i[PW-1], p_i} - {p_q[PW-1], p_q};

  // The data register loads only real samples so it keeps
  // its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov <= 1'b0;
      od <= '0;
    end else if (en) begin
      ov <= v2;
      if (v2) begin
        od <= diff;
      end
    end
  end

endmodule

// File: tb/tb_nco_quad_upconverter.sv
// Scoreboard bench for nco_quad_upconverter with an ideal sine/cos ROM model.
// Model-side and monitor-side processes sample on the falling edge.
module tb_nco_quad_upconverter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] phase_inc = '0;
  logic        phase_clr = 1'b0;
  logic [7:0]  rom_index;
  logic signed [7:0] rom_cos;
  logic signed [7:0] rom_sin;

  nco_quad_upconverter_if #(.DATA_W(16)) bus ();

  nco_quad_upconverter #(.DATA_W(16), .PHASE_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_inc (phase_inc),
    .phase_clr (phase_clr),
    .rom_index (rom_index),
    .rom_cos   (rom_cos),
    .rom_sin   (rom_sin),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  logic signed [7:0] cos_t [256];
  logic signed [7:0] sin_t [256];

  assign rom_cos = cos_t[rom_index];
  assign rom_sin = sin_t[rom_index];

  int checks = 0;
  int failures = 0;

  longint exp_q [$];
  logic [31:0] ph = '0;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Reference model: phase as a wrapping 32-bit number, ROM
  // looked up by its top byte, product computed in plain integers.
  logic [31:0] m_pn;
  logic [7:0]  m_idx;
  always @(negedge clk) begin
    if (rst_n) begin
      m_pn  = phase_clr ? 32'd0 : ph;
      m_idx = m_pn[31:24];
      chk(rom_index == m_idx, "rom_index", rom_index, m_idx);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(longint'(bus.in_i) * longint'(cos_t[m_idx])
                      - longint'(bus.in_q) * longint'(sin_t[m_idx]));
        ph = m_pn + phase_inc;
      end else begin
        ph = m_pn;
      end
    end
  end

  bit     stalled = 0;
  longint held = 0;
  longint got;
  longint want;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      got = longint'(bus.out_data);
      if (stalled) begin
        chk(bus.out_valid == 1'b1, "stall_valid", bus.out_valid, 1);
        chk(got == held, "stall_data", got, held);
      end
      if (bus.out_valid && !bus.out_ready)
        chk(bus.in_ready == 1'b0, "stall_in_ready", bus.in_ready, 0);
      if (bus.out_valid && exp_q.size() == 0) begin
        chk(0, "unexpected_output", got, 0);
      end else if (bus.out_valid && bus.out_ready) begin
        want = exp_q.pop_front();
        chk(got == want, "out_data", got, want);
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = got;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    phase_clr     = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      cos_t[k] = 8'(rnd(127.0 * $cos(6.283185307179586 * k / 256.0)));
      sin_t[k] = 8'(rnd(127.0 * $sin(6.283185307179586 * k / 256.0)));
    end
    bus.in_valid  = 1'b0;
    bus.in_i      = '0;
    bus.in_q      = '0;
    bus.out_ready = 1'b1;

    #12;
    chk(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
    chk(bus.out_data == '0, "rst_out_data", bus.out_data, 0);
    chk(rom_index == 8'd0, "rst_rom_index", rom_index, 0);
    chk(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // DC carrier with a latency probe on the first accept.
    phase_inc    = 32'd0;
    bus.in_i     = 16'sd100;
    bus.in_q     = 16'sd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk(bus.out_valid == (k == 3), "latency", bus.out_valid, k == 3);
    end
    for (int k = 0; k < 6; k++) cyc();
    drain();
    chk(bus.out_data == 25'sd12700, "dc_value", longint'(bus.out_data), 12700);

    // Quarter-rate carrier.
    phase_inc    = 32'h4000_0000;
    bus.in_i     = 16'sd100;
    bus.in_q     = 16'sd100;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 9; k++) cyc();
    drain();

    // Extremes at index 96.
    phase_clr    = 1'b1;
    cyc();
    phase_clr    = 1'b0;
    phase_inc    = 32'd96 << 24;
    bus.in_i     = 16'sd1;
    bus.in_q     = 16'sd1;
    bus.in_valid = 1'b1;
    cyc();
    phase_inc    = 32'd0;
    bus.in_i     = -16'sd32768;
    bus.in_q     = -16'sd32768;
    for (int k = 0; k < 3; k++) cyc();
    drain();
    chk(bus.out_data == 25'sd5898240, "extreme_value",
        longint'(bus.out_data), 5898240);

    // phase_clr on an accept, then the next sample at index 1.
    phase_inc    = 32'h0123_4567;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    phase_inc    = 32'h0100_0000;
    phase_clr    = 1'b1;
    @(negedge clk);
    chk(rom_index == 8'd0, "clr_accept_idx", rom_index, 0);
    cyc();
    phase_clr    = 1'b0;
    @(negedge clk);
    chk(rom_index == 8'd1, "clr_next_idx", rom_index, 1);
    cyc();
    drain();

    // phase_clr while idle.
    phase_inc    = 32'h0500_0000;
    bus.in_valid = 1'b1;
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    phase_clr    = 1'b1;
    cyc();
    phase_clr    = 1'b0;
    @(negedge clk);
    chk(rom_index == 8'd0, "idle_clr_idx", rom_index, 0);
    drain();

    // Random traffic with backpressure.
    for (int k = 0; k < 500; k++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.in_i      = 16'($urandom);
      bus.in_q      = 16'($urandom);
      phase_clr     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) phase_inc = $urandom;
      cyc();
    end
    drain();

    // Reset with three samples in flight.
    phase_inc     = 32'h1100_0000;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    bus.in_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk(bus.out_valid == 1'b0, "midrst_out_valid", bus.out_valid, 0);
    chk(rom_index == 8'd0, "midrst_rom_index", rom_index, 0);
    exp_q.delete();
    ph = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk(bus.in_ready == 1'b1, "post_rst_in_ready", bus.in_ready, 1);
    for (int k = 0; k < 8; k++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=%0d", checks, 0);
    $fatal(1);
  end

endmodule
